// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, a per-grant hold
// limit and a one-cycle timeout pulse when that limit revokes the grant.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_r, state_nxt_s;
  logic [2:0] ptr_r, ptr_nxt_s, idx_nxt_s, pick_s;
  logic [7:0] hold_cnt_r, hold_cnt_nxt_s, gnt_nxt_s;
  logic       valid_nxt_s, timeout_nxt_s;
  logic       hold_hit_s, early_s, release_s;

  // Scan runs ptr, ptr+1, ... ptr+7; iterating backwards lets the nearest hit win.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] cand;
    rr_pick = p;
    for (int i = 7; i >= 0; i--) begin
      cand = p + 3'(i);
      if (r[cand]) begin
        rr_pick = cand;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  assign pick_s     = rr_pick(req, ptr_r);
  assign hold_hit_s = (hold_cnt_r == HOLD_LAST);
  assign early_s    = done | ~req[gnt_idx];
  assign release_s  = (state_r == GRANT) & (early_s | hold_hit_s);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req != 8'h00) state_nxt_s = GRANT;
        else              state_nxt_s = IDLE;
      end
      GRANT: begin
        if (release_s) state_nxt_s = IDLE;
        else           state_nxt_s = GRANT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter
  always_comb begin
    ptr_nxt_s      = ptr_r;
    idx_nxt_s      = gnt_idx;
    hold_cnt_nxt_s = hold_cnt_r;
    gnt_nxt_s      = 8'h00;
    valid_nxt_s    = 1'b0;
    timeout_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req != 8'h00) begin
          idx_nxt_s      = pick_s;
          gnt_nxt_s      = 8'h01 << pick_s;
          valid_nxt_s    = 1'b1;
          hold_cnt_nxt_s = 8'h00;
        end else begin
          gnt_nxt_s   = 8'h00;
          valid_nxt_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          ptr_nxt_s     = gnt_idx + 3'd1;
          timeout_nxt_s = hold_hit_s & ~early_s;
        end else begin
          gnt_nxt_s      = gnt;
          valid_nxt_s    = 1'b1;
          hold_cnt_nxt_s = hold_cnt_r + 8'd1;
        end
      end
      default: begin
        gnt_nxt_s   = 8'h00;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r      <= 3'd0;
      gnt_idx    <= 3'd0;
      hold_cnt_r <= 8'h00;
      gnt        <= 8'h00;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      ptr_r      <= ptr_nxt_s;
      gnt_idx    <= idx_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      gnt        <= gnt_nxt_s;
      gnt_valid  <= valid_nxt_s;
      timeout    <= timeout_nxt_s;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 with hand-computed expectations.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int tests_run = 0;
  int tests_failed = 0;

  rr_arbiter8 #(.MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: gnt=%h valid=%b idx=%0d timeout=%b, expected 00/0/0/0",
               gnt, gnt_valid, gnt_idx, timeout);
    end
    done = 1'b1;
    step();
    tests_run++;
    if (gnt_valid !== 1'b0 || gnt !== 8'h00) begin
      tests_failed++;
      $display("FAIL idle_done_ignored: gnt=%h valid=%b, expected 00/0", gnt, gnt_valid);
    end
    done = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h01;
    step();
    tests_run++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: gnt=%h idx=%0d valid=%b, expected 01/0/1", gnt, gnt_idx, gnt_valid);
    end
    done = 1'b1;
    step();
    tests_run++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_release: gnt=%h valid=%b timeout=%b, expected 00/0/0", gnt, gnt_valid, timeout);
    end
    done = 1'b0;
    req  = 8'h00;
    step();
  endtask

  task automatic test_rotation();
    logic [7:0] exp_gnt;
    logic [2:0] exp_idx;
    do_reset();
    req = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      exp_idx = 3'(k % 8);
      exp_gnt = 8'h01 << exp_idx;
      tests_run++;
      if (gnt !== exp_gnt || gnt_idx !== exp_idx || gnt_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL rotation_grant[%0d]: gnt=%h idx=%0d valid=%b, expected %h/%0d/1",
                 k, gnt, gnt_idx, gnt_valid, exp_gnt, exp_idx);
      end
      done = 1'b1;
      step();
      tests_run++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rotation_gap[%0d]: gnt=%h valid=%b, expected 00/0", k, gnt, gnt_valid);
      end
      done = 1'b0;
      step();
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h00;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h40;
    step();
    tests_run++;
    if (gnt_idx !== 3'd6 || gnt !== 8'h40) begin
      tests_failed++;
      $display("FAIL wrap_first: gnt=%h idx=%0d, expected 40/6", gnt, gnt_idx);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 8'h41;
    step();
    tests_run++;
    if (gnt_idx !== 3'd0 || gnt !== 8'h01 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_next: gnt=%h idx=%0d valid=%b, expected 01/0/1", gnt, gnt_idx, gnt_valid);
    end
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h08;
    step();
    for (int c = 0; c < 16; c++) begin
      tests_run++;
      if (gnt !== 8'h08 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_hold[%0d]: gnt=%h valid=%b timeout=%b, expected 08/1/0",
                 c, gnt, gnt_valid, timeout);
      end
      step();
    end
    tests_run++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_pulse: gnt=%h valid=%b timeout=%b, expected 00/0/1", gnt, gnt_valid, timeout);
    end
    step();
    tests_run++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_regrant: gnt=%h idx=%0d timeout=%b, expected 08/3/0", gnt, gnt_idx, timeout);
    end
  endtask

  // Continues from the regrant to requester 3 left by test_timeout.
  task automatic test_drop_collision();
    req = 8'h0C;
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
        tests_failed++;
        $display("FAIL no_preempt[%0d]: gnt=%h idx=%0d, expected 08/3", c, gnt, gnt_idx);
      end
    end
    req = 8'h04;
    step();
    tests_run++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_release: gnt=%h valid=%b timeout=%b, expected 00/0/0", gnt, gnt_valid, timeout);
    end
    step();
    tests_run++;
    if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
      tests_failed++;
      $display("FAIL drop_next: gnt=%h idx=%0d, expected 04/2", gnt, gnt_idx);
    end
    for (int c = 0; c < 15; c++) step();
    tests_run++;
    if (gnt !== 8'h04 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL collision_hold: gnt=%h valid=%b, expected 04/1", gnt, gnt_valid);
    end
    done = 1'b1;
    step();
    tests_run++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL collision_release: gnt=%h valid=%b timeout=%b, expected 00/0/0", gnt, gnt_valid, timeout);
    end
    done = 1'b0;
    req  = 8'h00;
    step();
    tests_run++;
    if (timeout !== 1'b0 || gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL collision_quiet: timeout=%b valid=%b, expected 0/0", timeout, gnt_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'h20;
    step();
    tests_run++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
      tests_failed++;
      $display("FAIL async_setup: gnt=%h idx=%0d, expected 20/5", gnt, gnt_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: gnt=%h valid=%b idx=%0d timeout=%b, expected 00/0/0/0",
               gnt, gnt_valid, gnt_idx, timeout);
    end
    step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_rearb: gnt=%h idx=%0d timeout=%b, expected 20/5/0", gnt, gnt_idx, timeout);
    end
    req = 8'h00;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_drop_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
